// File: rtl/axis_fifo.sv
// axis_fifo: synchronous AXI-Stream FIFO, first-word fall-through, registered TREADY/TVALID.
// Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward gating of M_TVALID.
module axis_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 8
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    S_TVALID,
  output logic                    S_TREADY,
  input  logic [DATA_WIDTH-1:0]   S_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_TSTRB,
  input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
  input  logic                    S_TLAST,
  input  logic [ID_WIDTH-1:0]     S_TID,
  input  logic [DEST_WIDTH-1:0]   S_TDEST,
  input  logic [USER_WIDTH-1:0]   S_TUSER,
  output logic                    M_TVALID,
  input  logic                    M_TREADY,
  output logic [DATA_WIDTH-1:0]   M_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_TSTRB,
  output logic [DATA_WIDTH/8-1:0] M_TKEEP,
  output logic                    M_TLAST,
  output logic [ID_WIDTH-1:0]     M_TID,
  output logic [DEST_WIDTH-1:0]   M_TDEST,
  output logic [USER_WIDTH-1:0]   M_TUSER,
  output logic [$clog2(DEPTH):0]  level,
  output logic [$clog2(DEPTH):0]  pkt_count
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PTR_W   = ADDR_W + 1;
  localparam int KEEP_W  = DATA_WIDTH / 8;
  localparam int ENTRY_W = DATA_WIDTH + 2 * KEEP_W + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [ENTRY_W-1:0] wr_entry_s;
  logic [ENTRY_W-1:0] head_s;
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [PTR_W-1:0]   level_r, level_s, pkt_count_r, pkt_count_s;
  logic               s_tready_r, s_tready_s, m_tvalid_r, m_tvalid_s;
  logic               push_s, pop_s, full_s, empty_s;

  assign push_s     = S_TVALID && s_tready_r;
  assign pop_s      = m_tvalid_r && M_TREADY;
  assign wr_entry_s = {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER};
  assign head_s     = mem_r[rd_ptr_r[ADDR_W-1:0]];

  assign {M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER} = head_s;
  assign S_TREADY  = s_tready_r;
  assign M_TVALID  = m_tvalid_r;
  assign level     = level_r;
  assign pkt_count = pkt_count_r;

  // Next-state pointers, occupancy and handshake flags, all computed from post-edge state.
  always_comb begin
    wr_ptr_s    = wr_ptr_r;
    rd_ptr_s    = rd_ptr_r;
    pkt_count_s = pkt_count_r;
    if (push_s) begin
      wr_ptr_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    case ({push_s && S_TLAST, pop_s && M_TLAST})
      2'b10:   pkt_count_s = pkt_count_r + PTR_W'(1);
      2'b01:   pkt_count_s = pkt_count_r - PTR_W'(1);
      default: pkt_count_s = pkt_count_r;
    endcase
    level_s    = wr_ptr_s - rd_ptr_s;
    full_s     = ((wr_ptr_s ^ rd_ptr_s) == PTR_W'(DEPTH));
    empty_s    = (wr_ptr_s == rd_ptr_s);
    s_tready_s = !full_s;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    // A presented head stays valid until it is popped, even if the gating term drops.
    m_tvalid_s = (!empty_s && ((pkt_count_s != {PTR_W{1'b0}}) || full_s))
                 || (m_tvalid_r && !pop_s);
`else
    m_tvalid_s = !empty_s;
`endif
  end

  // Pointer, counter and handshake registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      level_r     <= {PTR_W{1'b0}};
      pkt_count_r <= {PTR_W{1'b0}};
      s_tready_r  <= 1'b0;
      m_tvalid_r  <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      level_r     <= level_s;
      pkt_count_r <= pkt_count_s;
      s_tready_r  <= s_tready_s;
      m_tvalid_r  <= m_tvalid_s;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero until first written.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_entry_s;
    end else begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= mem_r[wr_ptr_r[ADDR_W-1:0]];
    end
  end

endmodule
